// File: rtl/fetching.sv
// fetching: instruction fetch stage of the RISC-V pipeline.
// Holds the PC, runs a single-outstanding req/ready handshake to instruction
// memory and feeds `instruction`/`pc`/`valid`/`nop` to the decoding stage.
// A taken branch redirects the PC and emits a one-cycle `nop` flush pulse.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps to HALT).
module fetching #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        valid,
    output logic        nop,
    output logic        misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;        // next fetch address / pending redirect target
    logic [31:0] hold_q;      // address of the abandoned request during DRAIN
    logic [31:0] instr_q;
    logic [31:0] opc_q;
    logic        valid_q;
    logic        nop_q;
    logic        mis_q;

    logic [31:0] target_d;    // redirect address after alignment handling
    logic        trap_d;      // redirect must trap instead of fetching

    // Redirect target shaping: without the trap the low bits are dropped.
    always_comb begin
        target_d = TRAP_EN ? branch_target : {branch_target[31:2], 2'b00};
        trap_d   = TRAP_EN && (branch_target[1:0] != 2'b00);
    end

    // Memory-side request: only FETCH and DRAIN talk to memory, never in reset.
    always_comb begin
        imem_req  = !rst && ((state_q == S_FETCH) || (state_q == S_DRAIN));
        imem_addr = (state_q == S_DRAIN) ? hold_q : pc_q;
    end

    // Fetch FSM with registered decode-side outputs; outputs default to the
    // flushed value (all zero) every cycle unless a word is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0;
            instr_q <= 32'h0;
            opc_q   <= 32'h0;
            valid_q <= 1'b0;
            nop_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            instr_q <= 32'h0;
            opc_q   <= 32'h0;
            valid_q <= 1'b0;
            nop_q   <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (branch_taken) begin
                        // Redirect wins over any same-cycle transfer.
                        pc_q  <= target_d;
                        nop_q <= 1'b1;
                        if (trap_d) begin
                            mis_q   <= 1'b1;
                            state_q <= S_HALT;
                        end else if (imem_ready) begin
                            state_q <= S_FLUSH;
                        end else begin
                            // Request still outstanding: finish it on the old address.
                            hold_q  <= pc_q;
                            state_q <= S_DRAIN;
                        end
                    end else if (imem_ready) begin
                        instr_q <= imem_rdata;
                        opc_q   <= pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + 32'd4;
                    end
                end
                S_DRAIN: begin
                    // Later redirects only retarget; the nop pulse was already sent.
                    if (branch_taken) pc_q <= target_d;
                    if (branch_taken && trap_d) begin
                        mis_q   <= 1'b1;
                        state_q <= S_HALT;
                    end else if (imem_ready) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (branch_taken) begin
                        pc_q <= target_d;
                        if (trap_d) begin
                            mis_q   <= 1'b1;
                            state_q <= S_HALT;
                        end
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    // HALT: parked until reset.
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign pc          = opc_q;
    assign valid       = valid_q;
    assign nop         = nop_q;
    assign misalign    = mis_q;

endmodule

// File: tb/tb_fetching.sv
// tb_fetching: table-driven directed bench for the fetch stage.
// Memory model returns address ^ 32'hA5A5_0000 combinationally.
module tb_fetching;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        valid;
    logic        nop;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] XORV = 32'hA5A5_0000;

    fetching #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pc           (pc),
        .valid        (valid),
        .nop          (nop),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ XORV;

    typedef struct {
        logic        rst;
        logic        bt;
        logic [31:0] tgt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pcv;
        logic        nop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic b, logic [31:0] t, logic y,
                                logic q, logic [31:0] a, logic v, logic [31:0] p, logic n);
        vec_t x;
        x.rst = r; x.bt = b; x.tgt = t; x.rdy = y;
        x.req = q; x.addr = a; x.vld = v; x.pcv = p; x.nop = n;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got %h want %h", idx, name, got, exp);
        end
    endtask

    // Drive inputs, take one edge, settle off the edge.
    task automatic step(input logic r, input logic b, input logic [31:0] t, input logic y);
        rst = r; branch_taken = b; branch_target = t; imem_ready = y;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int idx, input logic q, input logic [31:0] a,
                              input logic v, input logic [31:0] p, input logic n, input logic m);
        chk("imem_req", idx, {31'h0, imem_req}, {31'h0, q});
        if (q) chk("imem_addr", idx, imem_addr, a);
        chk("valid", idx, {31'h0, valid}, {31'h0, v});
        chk("pc", idx, pc, v ? p : 32'h0);
        chk("instruction", idx, instruction, v ? (p ^ XORV) : 32'h0);
        chk("nop", idx, {31'h0, nop}, {31'h0, n});
        chk("misalign", idx, {31'h0, misalign}, {31'h0, m});
    endtask

    // nop must never be high on two consecutive sampled cycles.
    logic nop_prev = 1'b0;
    always @(negedge clk) begin
        if (nop && nop_prev) begin
            n_fail++;
            $display("FAIL nop_double: got 1 want 0");
        end
        nop_prev <= nop;
    end

    initial begin
        rst = 1'b1; branch_taken = 1'b0; branch_target = 32'h0; imem_ready = 1'b0;

        //           rst bt tgt           rdy  req addr          vld pc            nop
        // reset, then streaming 0,4,8
        vecs.push_back(mk(1, 0, 32'h0,       1,   0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h4,       1, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h8,       1, 32'h4,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'hC,       1, 32'h8,       0));
        // mid-run reset, restart, 3-cycle stall at address 8
        vecs.push_back(mk(1, 0, 32'h0,       1,   0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h4,       1, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h8,       1, 32'h4,       0));
        vecs.push_back(mk(0, 0, 32'h0,       0,   1, 32'h8,       0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       0,   1, 32'h8,       0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       0,   1, 32'h8,       0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'hC,       1, 32'h8,       0));
        // redirect to 0x100 with simultaneous transfer (dropped)
        vecs.push_back(mk(0, 1, 32'h100,     1,   0, 32'h0,       0, 32'h0,       1));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h100,     0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h104,     1, 32'h100,     0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h108,     1, 32'h104,     0));
        // get a request to 0x10, then redirect to 0x40 while it stalls
        vecs.push_back(mk(0, 1, 32'h10,      1,   0, 32'h0,       0, 32'h0,       1));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h10,      0, 32'h0,       0));
        vecs.push_back(mk(0, 1, 32'h40,      0,   1, 32'h10,      0, 32'h0,       1));
        vecs.push_back(mk(0, 0, 32'h0,       0,   1, 32'h10,      0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h40,      0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h44,      1, 32'h40,      0));
        // back-to-back redirects 0x80 then 0xC0
        vecs.push_back(mk(0, 1, 32'h80,      1,   0, 32'h0,       0, 32'h0,       1));
        vecs.push_back(mk(0, 1, 32'hC0,      1,   0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'hC0,      0, 32'h0,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'hC4,      1, 32'hC0,      0));
        // PC wrap at the top of the address space
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,       0, 32'h0,       1));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'hFFFF_FFFC, 0, 32'h0,     0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h0,       1, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 32'h0,       1,   1, 32'h4,       1, 32'h0,       0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].bt, vecs[i].tgt, vecs[i].rdy);
            check_outs(i, vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].pcv, vecs[i].nop, 1'b0);
        end

        // Misaligned redirect to 0x102.
`ifdef FETCH_MISALIGN_TRAP_EN
        step(0, 1, 32'h102, 1);
        check_outs(100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 32'h0, 1);
            check_outs(101 + k, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        step(1, 0, 32'h0, 1);
        check_outs(110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(0, 0, 32'h0, 1);
        check_outs(111, 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0);
`else
        step(0, 1, 32'h102, 1);
        check_outs(100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(0, 0, 32'h0, 1);
        check_outs(101, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        step(0, 0, 32'h0, 1);
        check_outs(102, 1'b1, 32'h104, 1'b1, 32'h100, 1'b0, 1'b0);
        step(0, 0, 32'h0, 1);
        check_outs(103, 1'b1, 32'h108, 1'b1, 32'h104, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetching.md
# fetching

Instruction fetch stage of the FPGA RISC V pipeline; the producer side of the fetch/decode boundary. Holds the program counter, runs a single-outstanding request/ready handshake to instruction memory, and drives `instruction` and `nop` into the decoding stage. On a taken branch it redirects the PC and issues the one-cycle `nop` pulse that makes decoding zero its pipeline register. Its output timing matches decoding's two-cycle flush window, so no wrong-path word is ever latched downstream.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` in 1: processor main clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `branch_taken` in 1: redirect request, sampled each posedge.
- `branch_target` in 32: redirect address, valid with `branch_taken`.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` in 1: transfer completes on the posedge where `imem_req`&`imem_ready`.
- `imem_rdata` in 32: instruction word, valid when `imem_ready`=1.
- `instruction` out 32: registered word to decoding; 0 when no valid word.
- `pc` out 32: address of `instruction`; 0 when `valid`=0.
- `valid` out 1: `instruction` holds a real fetched word.
- `nop` out 1: one-cycle flush pulse to decoding.
- `misalign` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- Registers: `pc_q` (next fetch address), state ∈ {FETCH, DRAIN, FLUSH, HALT}.
- Reset: `pc_q`=`RESET_PC`, state=FETCH, `instruction`=0, `pc`=0, `valid`=0, `nop`=0, `misalign`=0. `imem_req` is 0 during the reset cycle.
- `imem_addr`=`pc_q` in FETCH, and the held address in DRAIN.
- `imem_req`=1 in FETCH and DRAIN, 0 in FLUSH and HALT.
- FETCH, no redirect, transfer: `instruction`<=`imem_rdata`, `pc`<=`pc_q`, `valid`<=1, `pc_q`<=`pc_q`+4 (mod 2^32, wraps silently).
- FETCH, no redirect, no transfer: `instruction`<=0, `pc`<=0, `valid`<=0. This is a bubble equal to decoding's flushed value.
- Redirect (`branch_taken`=1 in FETCH):
  - `nop`<=1, `instruction`<=0, `valid`<=0, `pc_q`<=target.
  - Any same-cycle transfer is discarded.
  - With a transfer or no request outstanding: next state FLUSH.
  - With a request outstanding and no `imem_ready`: next state DRAIN, holding the old `imem_addr`.
- DRAIN: keep requesting the old address. Discard data on `imem_ready`, then go to FLUSH. Outputs stay 0.
- FLUSH: lasts one cycle with `nop`<=0 and outputs 0. Next state FETCH at `pc_q`.
- Redirect while in DRAIN/FLUSH: `pc_q`<=new target, no new `nop` pulse. In FLUSH the state stays FLUSH one more cycle; in DRAIN the state stays DRAIN.
- `nop` is never high for two consecutive cycles.

## Timing
- Fetch latency: a transfer at edge N puts the word on `instruction` after edge N, and decoding latches it at edge N+1.
- Throughput: one instruction per cycle while `imem_ready`=1.
- Redirect sampled at edge E:
  - `nop`=1 during E..E+1; decoding zeroes at E+1 and ignores E+2.
  - `imem_req`=0 during E..E+1 (non-DRAIN case).
  - The target is requested during E+1..E+2, and its word appears at E+2 at the earliest. Decoding latches it at E+3.
- Simultaneous `branch_taken` and `imem_ready`: redirect wins and the data is dropped.
- `rst` mid-operation overrides everything, including DRAIN. Memory is required to tolerate an abandoned request on reset.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: a redirect with `branch_target[1:0]`≠0 sets `misalign`<=1 (sticky) and emits the normal `nop`.
  - State goes to HALT: `imem_req`=0, outputs 0, no further fetches.
  - DRAIN completion is skipped: the request is dropped.
  - Only `rst` exits HALT.
- Not defined: `branch_target[1:0]` is forced to 0, `misalign` is tied 0, and HALT is unreachable.

## Test plan
- Reset release, `RESET_PC`=0, `imem_ready`=1 always, memory returns address^32'hA5A5_0000 -> `pc`=0,4,8 on consecutive cycles starting the cycle after the first transfer; `valid`=1 continuously.
- `imem_ready` low for 3 cycles at address 8 -> `imem_addr` holds 8; `instruction`=0 and `valid`=0 for 3 cycles; then the word for 8 appears with `pc`=8.
- `branch_taken` with target 0x100 at edge E, ready always high -> `nop`=1 for exactly one cycle; `instruction`=0 through E+2; word for 0x100 with `pc`=0x100 appears at E+2; no 0x104 word before it.
- Redirect to 0x40 while a request to 0x10 is stalled 2 more cycles -> `imem_addr` stays 0x10 until ready; that data is discarded; one FLUSH cycle; then request 0x40; `nop` pulses once.
- Two redirects (0x80 then 0xC0) on consecutive cycles -> single `nop` pulse; first delivered word has `pc`=0xC0.
- With `FETCH_MISALIGN_TRAP_EN`, target 0x102 -> `misalign`=1 and stays 1; `imem_req`=0 until `rst`. Without the macro, the same stimulus fetches 0x100 and `misalign`=0.
